mux8: RTL and testbench
=======================

// Module: mux8
// PURPOSE
//   8:1 single-bit multiplexer: drives y = data[sel] combinationally.
//   Also provides a registered copy y_q, one clk later, for pipelined consumers.
//   Leaf datapath block in the MIPS datapath; pure select logic, no handshake.
// PARAMETERS
//   N_IN    8                 number of data inputs (power of two, >= 2)
//   SEL_W   $clog2(N_IN) = 3  select width (derived, do not override)
// PORTS
//   clk    in   1      rising-edge clock (y_q register only)
//   rst    in   1      synchronous, active-high reset
//   data   in   N_IN   data inputs; data[i] is selected when sel == i
//   sel    in   SEL_W  select index
//   y      out  1      combinational output, data[sel]
//   y_q    out  1      registered output, y sampled at rising clk
//   Instantiate with named port connections only.
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - y = data[sel], purely combinational, zero-cycle latency.
//   - y does not depend on clk or rst; it is valid whenever inputs are stable.
//   - sel = 3'b000 selects data[0]; sel = 3'b111 selects data[7]; no other mapping.
//   - Any sel bit X/Z: y = X in simulation. No X-masking or default substitution.
//   - y_q: at posedge clk, y_q <= rst ? 1'b0 : y. One cycle latency from data/sel.
//   - Reset values: y_q = 0. y has no reset value; it follows the inputs.
//   - rst asserted mid-stream: y_q = 0 at the next edge. Release: y_q = y at the next edge.
//   - rst and input change in the same cycle: rst has priority.
//   - No state machine. No storage other than the y_q flop.
// CONFIGURATION
//   MUX8_ASSERT_EN defined: enables embedded SVA, with no functional change:
//     - concurrent check: on each posedge clk with !rst, y === data[sel]
//     - check: with !rst, $isunknown(sel) == 0
//     - check: with rst low in the previous cycle, y_q === $past(y)
//     - failures report via $error with sel, data and y.
//   MUX8_ASSERT_EN undefined: no assertions are compiled; the RTL is identical.
// STRUCTURE
//   Package mux8_pkg:
//     - localparam MUX8_N_IN = 8
//     - localparam MUX8_SEL_W = 3
//     - typedef logic [MUX8_SEL_W-1:0] mux8_sel_t
//   Sub-module mux8_mux2 (a, b, s, y: y = s ? b : a).
//     - Built as a generate tree of SEL_W levels; level k is driven by sel[k].
//     - Level 0 uses sel[0] on adjacent data pairs.
//   The y_q flop lives in the top module.
// TESTING
//   Vector format {sel[2:0], data[7:0], y_exp}, 12 bits.
//   Apply on the posedge, check y with === before the next posedge.
//   1. Exhaustive: all 2048 sel/data combinations -> y == data[sel]; 0 errors.
//   2. sel=3'b000, data=8'b0000_0001 -> y=1; sel=3'b111, same data -> y=0.
//   3. sel=3'b101, data=8'b0010_0000 -> y=1; data=8'b1101_1111 -> y=0 (walking zero).
//   4. rst=1 for 2 clk with data=8'hFF, sel=3'd3 -> y=1 throughout, y_q=0.
//      Release rst -> y_q=1 after one posedge.
//   5. Change sel 3'd2->3'd6 on data=8'b0100_0000 -> y goes 0->1 the same cycle.
//      y_q follows one clk later.
//   6. Build with MUX8_ASSERT_EN and force a wrong y -> $error fires.
//      Build without the macro -> bench results are identical.

Source files
------------

// File: rtl/mux8_pkg.sv
// -----------------------------------------------------------------------------
// mux8_pkg
//   Shared sizing constants and types for the mux8 select block.
//   - MUX8_N_IN  : number of data inputs (power of two, >= 2)
//   - MUX8_SEL_W : select width, derived from MUX8_N_IN
//   - mux8_sel_t : select index type
//   - mux8_lvl_base() : bit offset of a mux-tree level inside the flat node
//                       vector used by the top module
// -----------------------------------------------------------------------------
package mux8_pkg;

  localparam int MUX8_N_IN  = 8;
  localparam int MUX8_SEL_W = $clog2(MUX8_N_IN);

  typedef logic [MUX8_SEL_W-1:0] mux8_sel_t;

  // The tree is stored level after level in one vector: level 0 holds the
  // N data bits, level 1 holds N/2 bits, ... the last level holds the single
  // result. Level k therefore starts at 2N - 2N/2^k.
  function automatic int mux8_lvl_base(input int k);
    return (2 * MUX8_N_IN) - ((2 * MUX8_N_IN) >> k);
  endfunction

endpackage

// File: rtl/mux8_mux2.sv
// -----------------------------------------------------------------------------
// mux8_mux2
//   Single-bit 2:1 multiplexer, the leaf cell of the mux8 select tree.
//   Ports:
//     a  in  1  selected when s == 0
//     b  in  1  selected when s == 1
//     s  in  1  select
//     y  out 1  s ? b : a
// -----------------------------------------------------------------------------
module mux8_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux8.sv
// -----------------------------------------------------------------------------
// mux8
//   8:1 single-bit multiplexer for the MIPS datapath. y = data[sel] is purely
//   combinational; y_q is a registered copy one clk later for pipelined
//   consumers.
//   Ports:
//     clk   in   1      rising-edge clock (y_q register only)
//     rst   in   1      synchronous, active-high reset (y_q only)
//     data  in   8      data inputs; data[i] selected when sel == i
//     sel   in   3      select index
//     y     out  1      combinational data[sel]
//     y_q   out  1      y registered at rising clk, 0 while in reset
//   Build option:
//     MUX8_ASSERT_EN  when defined, compiles embedded SVA checks on y, sel and
//                     y_q. No functional change either way.
// -----------------------------------------------------------------------------
module mux8
  import mux8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUX8_N_IN-1:0] data,
  input  mux8_sel_t            sel,
  output logic                 y,
  output logic                 y_q
);

  localparam int N_IN  = MUX8_N_IN;
  localparam int SEL_W = MUX8_SEL_W;

  // Flat storage for every tree level: data at the bottom, result at the top.
  logic [2*N_IN-2:0] node;

  assign node[N_IN-1:0] = data;

  // Level k halves the candidate set using sel[k]; level 0 pairs adjacent
  // data bits, so the LSB of sel picks between data[2j] and data[2j+1].
  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    for (genvar j = 0; j < (N_IN >> (k + 1)); j++) begin : g_mux
      mux8_mux2 u_mux2 (
        .a (node[mux8_lvl_base(k) + 2*j]),
        .b (node[mux8_lvl_base(k) + 2*j + 1]),
        .s (sel[k]),
        .y (node[mux8_lvl_base(k + 1) + j])
      );
    end
  end

  assign y = node[2*N_IN-2];

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= y;
  end

`ifdef MUX8_ASSERT_EN
  a_y_select : assert property (@(posedge clk) disable iff (rst)
      y === data[sel])
    else $error("mux8: y mismatch sel=%0d data=%b y=%b", sel, data, y);

  a_sel_known : assert property (@(posedge clk) disable iff (rst)
      !$isunknown(sel))
    else $error("mux8: unknown sel=%b data=%b y=%b", sel, data, y);

  a_yq_follow : assert property (@(posedge clk)
      !rst |=> (y_q === $past(y)))
    else $error("mux8: y_q not previous y, sel=%0d data=%b y=%b y_q=%b",
                sel, data, y, y_q);
`endif

endmodule

// File: tb/tb_mux8.sv
// -----------------------------------------------------------------------------
// tb_mux8
//   Self-checking bench for mux8. Expected y is the bit at position sel of the
//   data word (shift and mask); expected y_q is that value from the previous
//   cycle, forced to 0 when rst was high in that cycle.
// -----------------------------------------------------------------------------
module tb_mux8;
  import mux8_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  mux8_sel_t  sel;
  logic       y;
  logic       y_q;

  int tests_run    = 0;
  int tests_failed = 0;

  // Value y_q must show after the next rising edge.
  logic q_pending;

  mux8 dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .sel  (sel),
    .y    (y),
    .y_q  (y_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b (rst=%b sel=%0d data=%b)",
               tag, obs, exp, rst, sel, data);
    end
  endtask

  function automatic logic ref_y(input logic [7:0] d, input logic [2:0] s);
    logic [7:0] shifted;
    shifted = d >> s;
    return shifted[0];
  endfunction

  // One cycle: after the rising edge check y_q against the value captured
  // from the previous cycle, then drive new inputs and check y combinationally
  // before the next edge.
  task automatic step(input logic r, input logic [7:0] d, input logic [2:0] s,
                      input string tag);
    @(posedge clk);
    #1;
    check({tag, "_yq"}, y_q, q_pending);
    rst  = r;
    data = d;
    sel  = s;
    #1;
    check({tag, "_y"}, y, ref_y(d, s));
    q_pending = r ? 1'b0 : ref_y(d, s);
  endtask

  initial begin
    rst       = 1'b1;
    data      = 8'h00;
    sel       = '0;
    q_pending = 1'b0;

    // Reset state.
    step(1'b1, 8'h00, 3'd0, "reset");
    step(1'b1, 8'hA5, 3'd2, "reset");

    // Exhaustive sweep of every sel/data combination.
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] v;
      v = 11'(i);
      step(1'b0, v[7:0], v[10:8], "exh");
    end

    // Boundary selects.
    step(1'b0, 8'b0000_0001, 3'b000, "sel0");
    step(1'b0, 8'b0000_0001, 3'b111, "sel7");

    // Walking one / walking zero at sel=5.
    step(1'b0, 8'b0010_0000, 3'b101, "walk1");
    step(1'b0, 8'b1101_1111, 3'b101, "walk0");

    // Reset held two cycles with y active, then released.
    step(1'b1, 8'hFF, 3'd3, "rst_hold");
    step(1'b1, 8'hFF, 3'd3, "rst_hold");
    step(1'b0, 8'hFF, 3'd3, "rst_rel");
    step(1'b0, 8'hFF, 3'd3, "rst_rel");

    // Select change 2 -> 6 flips y in the same cycle; y_q one cycle later.
    step(1'b0, 8'b0100_0000, 3'd2, "selchg");
    step(1'b0, 8'b0100_0000, 3'd6, "selchg");
    step(1'b0, 8'b0100_0000, 3'd6, "selchg");

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [7:0] d;
      logic [2:0] s;
      r = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      s = 3'($urandom_range(0, 7));
      step(r, d, s, "rand");
    end

    // Final y_q capture.
    step(1'b0, 8'h00, 3'd0, "tail");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
